// File: rtl/pilot_sched_pkg.sv
// Receiver-wide constants and types shared by the pilot scheduling logic
// and, later, the equalizer.
package pilot_sched_pkg;

    localparam int Q       = 16;
    localparam int NFFT    = 64;
    localparam int IDX_W   = $clog2(NFFT);
    localparam int P0      = 7;
    localparam int P1      = 21;
    localparam int P2      = 43;
    localparam int P3      = 57;
    localparam int AVG_LAT = 2;
    localparam int LAT_W   = $clog2(AVG_LAT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } sched_state_e;

endpackage

// File: rtl/pilot_index_dec.sv
// Combinational decoder: bin index -> pilot flag and pilot slot (0..3).
module pilot_index_dec
    import pilot_sched_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic             is_pilot,
    output logic [1:0]       pilot_slot
);

    always_comb begin
        is_pilot   = 1'b0;
        pilot_slot = 2'd0;
        if (idx == IDX_W'(P0)) begin
            is_pilot   = 1'b1;
            pilot_slot = 2'd0;
        end else if (idx == IDX_W'(P1)) begin
            is_pilot   = 1'b1;
            pilot_slot = 2'd1;
        end else if (idx == IDX_W'(P2)) begin
            is_pilot   = 1'b1;
            pilot_slot = 2'd2;
        end else if (idx == IDX_W'(P3)) begin
            is_pilot   = 1'b1;
            pilot_slot = 2'd3;
        end
    end

endmodule

// File: rtl/pilot_sched_ctrl.sv
// Steers FFT bins to the pilot averager or the equalizer data path and keeps
// the averager's modulo-4 pilot grouping aligned across aborted symbols.
module pilot_sched_ctrl
    import pilot_sched_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sym_start,
    input  logic                in_valid,
    input  logic [Q-1:0]        in_r,
    input  logic [Q-1:0]        in_i,
    output logic                pilot_en,
    output logic [Q-1:0]        pilot_r,
    output logic [Q-1:0]        pilot_i,
    output logic                data_valid,
    output logic [Q-1:0]        data_r,
    output logic [Q-1:0]        data_i,
    output logic [IDX_W-1:0]    data_idx,
    output logic                coef_valid,
    output logic                sym_done,
    output logic                abort_err
);

    sched_state_e      state_q, state_d;
    logic [IDX_W-1:0]  bin_cnt_q, bin_cnt_d;
    logic [1:0]        pilot_cnt_q, pilot_cnt_d;
    logic [LAT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [LAT_W-1:0]  coef_cnt_q, coef_cnt_d;
    logic              skid_vld_q, skid_vld_d;
    logic [Q-1:0]      skid_r_q, skid_r_d, skid_i_q, skid_i_d;
    logic              pilot_en_q, pilot_en_d;
    logic [Q-1:0]      pilot_r_q, pilot_r_d, pilot_i_q, pilot_i_d;
    logic              data_valid_q, data_valid_d;
    logic [Q-1:0]      data_r_q, data_r_d, data_i_q, data_i_d;
    logic [IDX_W-1:0]  data_idx_q, data_idx_d;
    logic              coef_valid_q, coef_valid_d;
    logic              sym_done_q, sym_done_d;
    logic              abort_err_q, abort_err_d;

    logic              start;
    logic              route_go;
    logic [IDX_W-1:0]  route_idx;
    logic [Q-1:0]      route_r, route_i;
    logic              restart;
    logic              pad;
    logic              is_pilot;
    logic [1:0]        pilot_slot;

    assign start = in_valid & sym_start;

    // Pick which bin (if any) is routed this cycle, and whether a padding pilot goes out.
    always_comb begin
        route_go  = 1'b0;
        route_idx = '0;
        route_r   = in_r;
        route_i   = in_i;
        restart   = 1'b0;
        pad       = 1'b0;
        case (state_q)
            ST_IDLE, ST_WAIT: begin
                if (start) begin
                    route_go = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    if (sym_start && (bin_cnt_q != '0)) begin
                        restart = 1'b1;
                        if (pilot_cnt_q == 2'd0) begin
                            route_go = 1'b1;
                        end else begin
                            pad = 1'b1;
                        end
                    end else begin
                        route_go  = 1'b1;
                        route_idx = bin_cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (pilot_cnt_q != 2'd0) begin
                    pad = 1'b1;
                end else if (skid_vld_q) begin
                    route_go = 1'b1;
                    route_r  = skid_r_q;
                    route_i  = skid_i_q;
                end
            end
            default: ;
        endcase
    end

    pilot_index_dec u_dec (
        .idx        (route_idx),
        .is_pilot   (is_pilot),
        .pilot_slot (pilot_slot)
    );

    always_comb begin
        state_d      = state_q;
        bin_cnt_d    = bin_cnt_q;
        pilot_cnt_d  = pilot_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        coef_cnt_d   = coef_cnt_q;
        skid_vld_d   = skid_vld_q;
        skid_r_d     = skid_r_q;
        skid_i_d     = skid_i_q;
        pilot_en_d   = 1'b0;
        pilot_r_d    = pilot_r_q;
        pilot_i_d    = pilot_i_q;
        data_valid_d = 1'b0;
        data_r_d     = data_r_q;
        data_i_d     = data_i_q;
        data_idx_d   = data_idx_q;
        coef_valid_d = 1'b0;
        sym_done_d   = 1'b0;
        abort_err_d  = 1'b0;

        // coef_valid is timed from the 4th real pilot, independent of the FSM.
        if (coef_cnt_q != '0) begin
            coef_cnt_d   = coef_cnt_q - LAT_W'(1);
            coef_valid_d = (coef_cnt_q == LAT_W'(1));
        end

        if (state_q == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q - LAT_W'(1);
            if (wait_cnt_q <= LAT_W'(1)) begin
                state_d = ST_IDLE;
            end
        end

        if (restart) begin
            abort_err_d  = 1'b1;
            coef_cnt_d   = '0;
            coef_valid_d = 1'b0;
            bin_cnt_d    = '0;
            skid_vld_d   = pad;
            skid_r_d     = in_r;
            skid_i_d     = in_i;
        end

        if (pad) begin
            pilot_en_d  = 1'b1;
            pilot_r_d   = '0;
            pilot_i_d   = '0;
            pilot_cnt_d = pilot_cnt_q + 2'd1;
            state_d     = ST_FLUSH;
        end

        if (route_go) begin
            state_d    = ST_RUN;
            bin_cnt_d  = route_idx;
            skid_vld_d = 1'b0;
            if (is_pilot) begin
                pilot_en_d  = 1'b1;
                pilot_r_d   = route_r;
                pilot_i_d   = route_i;
                pilot_cnt_d = pilot_cnt_q + 2'd1;
                if ((pilot_cnt_q == 2'd3) && (pilot_slot == 2'd3)) begin
                    coef_cnt_d = LAT_W'(AVG_LAT);
                end
            end else begin
                data_valid_d = 1'b1;
                data_r_d     = route_r;
                data_i_d     = route_i;
                data_idx_d   = route_idx;
            end
            if (route_idx == IDX_W'(NFFT - 1)) begin
                sym_done_d = 1'b1;
                state_d    = ST_WAIT;
                wait_cnt_d = LAT_W'(AVG_LAT);
                bin_cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bin_cnt_q    <= '0;
            pilot_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            coef_cnt_q   <= '0;
            skid_vld_q   <= 1'b0;
            skid_r_q     <= '0;
            skid_i_q     <= '0;
            pilot_en_q   <= 1'b0;
            pilot_r_q    <= '0;
            pilot_i_q    <= '0;
            data_valid_q <= 1'b0;
            data_r_q     <= '0;
            data_i_q     <= '0;
            data_idx_q   <= '0;
            coef_valid_q <= 1'b0;
            sym_done_q   <= 1'b0;
            abort_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_cnt_q    <= bin_cnt_d;
            pilot_cnt_q  <= pilot_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            coef_cnt_q   <= coef_cnt_d;
            skid_vld_q   <= skid_vld_d;
            skid_r_q     <= skid_r_d;
            skid_i_q     <= skid_i_d;
            pilot_en_q   <= pilot_en_d;
            pilot_r_q    <= pilot_r_d;
            pilot_i_q    <= pilot_i_d;
            data_valid_q <= data_valid_d;
            data_r_q     <= data_r_d;
            data_i_q     <= data_i_d;
            data_idx_q   <= data_idx_d;
            coef_valid_q <= coef_valid_d;
            sym_done_q   <= sym_done_d;
            abort_err_q  <= abort_err_d;
        end
    end

    assign pilot_en   = pilot_en_q;
    assign pilot_r    = pilot_r_q;
    assign pilot_i    = pilot_i_q;
    assign data_valid = data_valid_q;
    assign data_r     = data_r_q;
    assign data_i     = data_i_q;
    assign data_idx   = data_idx_q;
    assign coef_valid = coef_valid_q;
    assign sym_done   = sym_done_q;
    assign abort_err  = abort_err_q;

endmodule

// File: tb/tb_pilot_sched_ctrl.sv
// Directed bench for pilot_sched_ctrl: per-cycle expected outputs are queued
// with the stimulus and compared one cycle later.
module tb_pilot_sched_ctrl;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sym_start, in_valid;
    logic [15:0] in_r, in_i;
    logic        pilot_en, data_valid, coef_valid, sym_done, abort_err;
    logic [15:0] pilot_r, pilot_i, data_r, data_i;
    logic [5:0]  data_idx;

    always #5 clk = ~clk;

    pilot_sched_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_start  (sym_start),
        .in_valid   (in_valid),
        .in_r       (in_r),
        .in_i       (in_i),
        .pilot_en   (pilot_en),
        .pilot_r    (pilot_r),
        .pilot_i    (pilot_i),
        .data_valid (data_valid),
        .data_r     (data_r),
        .data_i     (data_i),
        .data_idx   (data_idx),
        .coef_valid (coef_valid),
        .sym_done   (sym_done),
        .abort_err  (abort_err)
    );

    typedef struct packed {
        logic        pe;
        logic [15:0] pr;
        logic [15:0] pi;
        logic        dv;
        logic [15:0] dr;
        logic [15:0] di;
        logic [5:0]  idx;
        logic        sd;
        logic        ab;
        logic        cv;
    } out_t;

    out_t exp_q[$];
    int   coef_due[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    function automatic out_t sample_out();
        out_t o;
        o.pe = pilot_en;  o.pr = pilot_r;  o.pi = pilot_i;
        o.dv = data_valid; o.dr = data_r;  o.di = data_i; o.idx = data_idx;
        o.sd = sym_done;  o.ab = abort_err; o.cv = coef_valid;
        return o;
    endfunction

    // Sample fields only matter while their qualifier is expected high.
    function automatic out_t mask(out_t o, out_t ex);
        out_t m = o;
        if (!ex.pe) begin m.pr = '0; m.pi = '0; end
        if (!ex.dv) begin m.dr = '0; m.di = '0; m.idx = '0; end
        return m;
    endfunction

    function automatic out_t exp_bin(int k, logic [15:0] r, logic [15:0] i);
        out_t e = '0;
        if (k == 7 || k == 21 || k == 43 || k == 57) begin
            e.pe = 1'b1; e.pr = r; e.pi = i;
        end else begin
            e.dv = 1'b1; e.dr = r; e.di = i; e.idx = 6'(k);
        end
        e.sd = (k == 63);
        return e;
    endfunction

    task automatic check(string tag, out_t ex, bit raw);
        out_t obs, e;
        obs = raw ? sample_out() : mask(sample_out(), ex);
        e   = raw ? ex : mask(ex, ex);
        n_checks++;
        assert (obs === e) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] r,
                         input logic [15:0] i, input out_t e, input bit fourth,
                         input string tag);
        out_t ex;
        in_valid = v; sym_start = s; in_r = r; in_i = i;
        exp_q.push_back(e);
        if (fourth) coef_due.push_back(cyc + 1 + LAT);
        if (v) $display("%0t %s v=%0b s=%0b r=%h i=%h", $time, tag, v, s, r, i);
        @(posedge clk);
        #1;
        cyc++;
        ex = exp_q.pop_front();
        if (coef_due.size() > 0 && coef_due[0] == cyc) begin
            ex.cv = 1'b1;
            void'(coef_due.pop_front());
        end
        check(tag, ex, 1'b0);
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 1'b0, 16'h0, 16'h0, '0, 1'b0, tag);
    endtask

    task automatic send_range(input int k0, input int k1, input bit first_start,
                              input bit gap, input int off, input bit full,
                              input string tag);
        for (int k = k0; k <= k1; k++) begin
            logic [15:0] r, i;
            r = 16'(k + off);
            i = 16'(-(k + off));
            drive(1'b1, first_start && (k == k0), r, i, exp_bin(k, r, i),
                  full && (k == 57), $sformatf("%s_bin%0d", tag, k));
            if (gap) idle({tag, "_gap"});
        end
    endtask

    task automatic check_no_pending(input string tag);
        n_checks++;
        assert (coef_due.size() === 0) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d pending coef_valid expected 0", tag, coef_due.size());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        out_t e;
        rst_n = 1'b0; in_valid = 1'b1; sym_start = 1'b1;
        in_r = 16'h1234; in_i = 16'h5678;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; sym_start = 1'b0;
        @(posedge clk);
        #1;

        // Valid bins without a start marker are dropped in IDLE.
        drive(1'b1, 1'b0, 16'h0005, 16'h0005, '0, 1'b0, "idle_drop0");
        drive(1'b1, 1'b0, 16'h0006, 16'h0006, '0, 1'b0, "idle_drop1");

        send_range(0, 63, 1'b1, 1'b0, 0, 1'b1, "clean");
        repeat (3) idle("clean_tail");

        send_range(0, 63, 1'b1, 1'b1, 0, 1'b1, "gapped");
        repeat (3) idle("gapped_tail");

        // Restart after two pilots: two zero pads, inputs during FLUSH dropped.
        send_range(0, 29, 1'b1, 1'b0, 100, 1'b0, "abort2_pre");
        e = '0; e.pe = 1'b1; e.ab = 1'b1;
        drive(1'b1, 1'b1, 16'd200, 16'(-200), e, 1'b0, "abort2_pad1");
        e.ab = 1'b0;
        drive(1'b1, 1'b0, 16'h7777, 16'h7777, e, 1'b0, "abort2_pad2");
        drive(1'b1, 1'b0, 16'h5555, 16'h5555, exp_bin(0, 16'd200, 16'(-200)),
              1'b0, "abort2_skid");
        send_range(1, 63, 1'b0, 1'b0, 200, 1'b1, "abort2_new");
        repeat (3) idle("abort2_tail");

        // Restart before any pilot: no flush, new bin 0 out immediately.
        send_range(0, 4, 1'b1, 1'b0, 300, 1'b0, "abort0_pre");
        e = exp_bin(0, 16'd400, 16'(-400));
        e.ab = 1'b1;
        drive(1'b1, 1'b1, 16'd400, 16'(-400), e, 1'b0, "abort0_restart");
        send_range(1, 63, 1'b0, 1'b0, 400, 1'b1, "abort0_new");

        // Back-to-back symbols, with a duplicate marker on bin 1 of the second.
        send_range(0, 63, 1'b1, 1'b0, 500, 1'b1, "b2b_a");
        send_range(0, 0, 1'b1, 1'b0, 600, 1'b1, "b2b_b");
        drive(1'b1, 1'b1, 16'd601, 16'(-601), exp_bin(1, 16'd601, 16'(-601)),
              1'b0, "dup_marker");
        send_range(2, 63, 1'b0, 1'b0, 600, 1'b1, "b2b_b");
        repeat (3) idle("b2b_tail");
        check_no_pending("pending_before_reset");

        // Asynchronous reset in the middle of a symbol.
        send_range(0, 39, 1'b1, 1'b0, 700, 1'b0, "rst_pre");
        in_valid = 1'b1; sym_start = 1'b0; in_r = 16'd740; in_i = 16'(-740);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", '0, 1'b1);
        @(posedge clk);
        #1;
        check("rst_hold", '0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release", '0, 1'b1);

        send_range(0, 63, 1'b1, 1'b0, 800, 1'b1, "post_rst");
        repeat (3) idle("post_rst_tail");
        check_no_pending("pending_at_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pilot_sched_ctrl.md
# pilot_sched_ctrl

Sequencing controller for the pilot averager in the receiver chain. It sits between the FFT output stream and the pilot averager / equalizer. It tracks the subcarrier index of each incoming FFT bin and steers the four pilot bins of every OFDM symbol into the averager with a correctly framed enable. Data bins go to the equalizer path, and the controller signals when the averaged pilot for the symbol is valid. It also keeps the averager's internal modulo-4 grouping aligned when a symbol is aborted.

## Interface
- Q, 16, sample word width (signed, Q_dec fractional bits carried unchanged)
- NFFT, 64, bins per OFDM symbol
- P0 / P1 / P2 / P3, 7 / 21 / 43 / 57, pilot bin indices, strictly ascending, each < NFFT
- AVG_LAT, 2, cycles from the 4th pilot_en to a valid averager output

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- sym_start  in  1  marks bin 0 of a symbol; sampled only with in_valid
- in_valid  in  1  in_r / in_i carry one FFT bin this cycle
- in_r, in_i  in  Q  signed bin sample
- pilot_en  out  1  drives the averager's data_en
- pilot_r, pilot_i  out  Q  drives the averager's pilot inputs
- data_valid  out  1  a data (non-pilot) bin is on data_r / data_i
- data_r, data_i  out  Q  data bin sample
- data_idx  out  clog2(NFFT)  bin index of the current data output
- coef_valid  out  1  one-cycle pulse: averager output is valid for the just-completed symbol
- sym_done  out  1  one-cycle pulse on the last bin of a complete symbol
- abort_err  out  1  one-cycle pulse when a symbol is restarted before completion

## Operation
- FSM states:
  - IDLE: waits for in_valid & sym_start, then goes to RUN with bin_cnt=0.
  - RUN: each in_valid advances bin_cnt. When bin_cnt == NFFT-1 is accepted, the FSM pulses sym_done and goes to WAIT.
  - WAIT: counts AVG_LAT cycles, pulses coef_valid, then returns to IDLE.
  - FLUSH: issues padding pilots, then enters RUN for the new symbol.
- Bin routing:
  - A bin whose index matches P0..P3 is a pilot: pilot_en=1, pilot_r/i = input.
  - Any other bin is data: data_valid=1, data_idx = bin index.
  - A bin never asserts both pilot_en and data_valid.
- pilot_cnt (0..3) counts issued pilot_en pulses modulo 4 and mirrors the averager's internal group counter.
- Restart during RUN:
  - Trigger: in_valid & sym_start arrives while bin_cnt != 0.
  - Pulse abort_err.
  - If pilot_cnt != 0, enter FLUSH and emit (4 - pilot_cnt) back-to-back pilot_en with pilot_r/i = 0. No coef_valid is generated for the aborted symbol.
  - The triggering bin is held in a one-entry skid register and processed as bin 0 of the new symbol after FLUSH.
  - in_valid arriving during FLUSH is a protocol violation; those bins are dropped.
- sym_start in WAIT starts a new symbol immediately. coef_valid still fires at its scheduled cycle; the averager output remains stable because the next pilot cannot complete a group within AVG_LAT.
- sym_start is ignored while bin_cnt == 0 in RUN, i.e. a duplicate marker.
- in_valid without sym_start in IDLE is dropped silently.
- Arithmetic: bin_cnt is clog2(NFFT) bits and never wraps past NFFT-1; samples pass through unmodified.

## Timing
- All outputs are registered. Bin routing latency is 1 cycle (input in cycle t → pilot_en / data_valid in t+1).
- coef_valid asserts exactly AVG_LAT cycles after the cycle in which the 4th pilot_en of the symbol is high.
- sym_done asserts in the same cycle as the output of bin NFFT-1.
- FLUSH occupies (4 - pilot_cnt) cycles; the skid bin emerges on the cycle after FLUSH ends.
- Reset values: every output is 0; FSM=IDLE; bin_cnt=0; pilot_cnt=0; skid register empty.
- Reset asserted mid-symbol takes effect immediately (asynchronous). The averager shares the same reset, so both restart aligned.

## Structure
- Shared package (receiver-wide): NFFT, pilot index constants, Q / Q_dec, FSM state enum.
- One natural sub-module: pilot_index_dec, a combinational decoder from bin index to {is_pilot, pilot_slot}, reused later by the equalizer.

## Test plan
- Clean symbol: sym_start + 64 consecutive bins (value = index) → pilot_en at bins 7, 21, 43, 57 carrying values 7, 21, 43, 57; 60 data_valid with matching data_idx; sym_done on bin 63; coef_valid 2 cycles after bin 57's pilot_en.
- Gapped input: the same symbol with in_valid low every other cycle → identical output sequence stretched in time; coef_valid timing is still relative to the 4th pilot_en.
- Abort after 2 pilots: sym_start at bin 30 → abort_err pulse; 2 zero-valued pilot_en; the following clean symbol yields an averager output equal to the mean of its own 4 pilots.
- Abort with pilot_cnt=0: restart at bin 5 → abort_err, no FLUSH cycles, new bin 0 emitted on the next cycle.
- Back-to-back symbols: sym_start in WAIT → second symbol's bin 0 routes without loss; two coef_valid pulses 64+ cycles apart.
- Reset at bin 40 → all outputs 0 next cycle; the next symbol behaves as the clean-symbol case.
